multi_cycle_control_unit: RTL
=============================

# multi_cycle_control_unit

Sequencing controller for the multi-cycle RV32I datapath. Each instruction runs as a series of states (fetch, decode, execute, memory, write-back) over one shared ALU, one unified memory port, the register file and the immediate generator. The block drives every datapath select and write-enable, waits on a memory-ready handshake, and resolves branches from the ALU compare result. It sits beside the datapath in the top-level CPU and takes the 7-bit opcode from the instruction register.

## Interface
Parameters:
- none; opcode values come from `opcodes.v`.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  IR[6:0]; stable from ID until the instruction's last cycle.
- bcond  in  1  ALU branch-compare result; valid in EX of BRANCH.
- halt_req  in  1  datapath flag: ECALL with x17 == 10.
- mem_ready  in  1  memory completes the requested access this cycle.
- pc_write  out  1  PC loads the value chosen by pc_source.
- pc_source  out  1  0 = live ALU result, 1 = ALUOut register.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR loads memory read data.
- mdr_write  out  1  MDR loads memory read data.
- reg_write  out  1  register-file write of rd.
- mem_to_reg  out  1  rd data: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = rs1 (A register).
- alu_src_b  out  2  0 = rs2 (B register), 1 = constant 4, 2 = immediate; 3 is unused.
- alu_op  out  2  0 = add, 1 = branch compare (funct3), 2 = funct-decoded.
- alu_out_write  out  1  ALUOut register loads the ALU result.
- is_halted  out  1  CPU halted.
- state  out  3  current state, for debug.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, BR_TAKEN=5, HALT=6. Encoding 7 is illegal and goes to IF.
- Outputs are combinational from state, opcode, bcond, halt_req and mem_ready. Any output not listed for a state is 0.
- IF: mem_read=1, i_or_d=0. When mem_ready=1: ir_write=1 and move to ID. Otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=1, alu_op=0, alu_out_write=1, so ALUOut = PC+4. Always move to EX.
- EX for R-type: alu_src_a=1, alu_src_b=0, alu_op=2, alu_out_write=1. Move to WB.
- EX for I-arith: same as R-type but alu_src_b=2. Move to WB.
- EX for LOAD and STORE: alu_src_a=1, alu_src_b=2, alu_op=0, alu_out_write=1. Move to MEM.
- EX for BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1.
  - bcond=0: pc_write=1, pc_source=1 (PC+4), move to IF.
  - bcond=1: move to BR_TAKEN.
- EX for JAL: alu_src_a=0, alu_src_b=2, alu_op=0; pc_write=1, pc_source=0; reg_write=1, mem_to_reg=0 (rd = PC+4). Move to IF.
- EX for JALR: same as JAL but alu_src_a=1.
- EX for ECALL:
  - halt_req=1: move to HALT, no PC write.
  - halt_req=0: pc_write=1, pc_source=1, move to IF.
- EX for any other opcode: treated as NOP. pc_write=1, pc_source=1, move to IF.
- MEM for LOAD: mem_read=1, i_or_d=1. When mem_ready=1: mdr_write=1 and move to WB.
- MEM for STORE: mem_write=1, i_or_d=1. When mem_ready=1: alu_src_a=0, alu_src_b=1, pc_write=1, pc_source=0 (PC+4), move to IF.
- WB: reg_write=1, mem_to_reg = (opcode==LOAD). In the same cycle: alu_src_a=0, alu_src_b=1, alu_op=0, pc_write=1, pc_source=0. Move to IF.
- BR_TAKEN: alu_src_a=0, alu_src_b=2, alu_op=0, pc_write=1, pc_source=0 (PC+imm). Move to IF.
- HALT: is_halted=1 and all other outputs 0. HALT is absorbing until reset.

## Timing
- While reset_n=0: state=IF and every output is forced to 0, including mem_read.
- First IF request appears in the cycle after reset_n rises.
- Reset asserted mid-instruction (any state) aborts it at once. No write-enable may be asserted in any cycle where reset_n=0.
- The state register updates on the rising clk edge. Outputs are valid in the same cycle as the state that produces them.
- mem_read and mem_write stay asserted and constant until the mem_ready cycle; i_or_d stays constant throughout.
- mem_ready is ignored in ID, EX, WB, BR_TAKEN and HALT.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - 3 cycles: JAL, JALR, ECALL, branch not taken, NOP.
  - 4 cycles: R-type, I-arith, STORE, branch taken.
  - 5 cycles: LOAD.
- Each wait cycle on a memory access adds 1 cycle.
- Exactly one pc_write pulse per retired instruction; none for a halting ECALL.

## Test plan
- Reset release, opcode=0110011 (add), mem_ready tied 1 -> state sequence 0,1,2,4,0. reg_write=1 only in WB. Exactly one pc_write, with pc_source=0.
- LOAD with mem_ready low for 2 cycles in both IF and MEM -> 9 cycles total. mem_read held in every wait cycle. ir_write and mdr_write each pulse once. mem_to_reg=1 in WB.
- BRANCH with bcond=0, then with bcond=1 -> not taken: 0,1,2,0 with pc_source=1. Taken: 0,1,2,5,0 with a single pc_write, in BR_TAKEN.
- JAL -> in EX: reg_write=1, pc_write=1, pc_source=0, alu_src_b=2. Returns to IF after 3 cycles.
- ECALL with halt_req=1 -> state 6, is_halted=1, no pc_write. Stays halted for 20 cycles with all other outputs 0.
- reset_n pulsed low in MEM of a STORE with mem_ready=0 -> mem_write drops to 0 asynchronously. state=0 after release. No pc_write is issued.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Sequencing FSM for the multi-cycle RV32I datapath. It drives every datapath select and
// write-enable from the current state, the opcode, the branch result and the memory handshake.
module multi_cycle_control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       alu_out_write,
  output logic       is_halted,
  output logic [2:0] state
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIArith = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBFour = 2'd1;
  localparam logic [1:0] SrcBImm  = 2'd2;

  localparam logic [1:0] AluAdd    = 2'd0;
  localparam logic [1:0] AluBranch = 2'd1;
  localparam logic [1:0] AluFunct  = 2'd2;

  typedef enum logic [2:0] {
    StIf      = 3'd0,
    StId      = 3'd1,
    StEx      = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StBrTaken = 3'd5,
    StHalt    = 3'd6
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    alu_op        = AluAdd;
    alu_out_write = 1'b0;
    is_halted     = 1'b0;

    case (state_q)
      StIf: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = StId;
        end
      end

      // ALUOut = PC + 4, later used as the fall-through PC and the link value.
      StId: begin
        alu_src_b     = SrcBFour;
        alu_out_write = 1'b1;
        state_d       = StEx;
      end

      StEx: begin
        case (opcode)
          OpRType, OpIArith: begin
            alu_src_a     = 1'b1;
            alu_src_b     = (opcode == OpIArith) ? SrcBImm : SrcBReg;
            alu_op        = AluFunct;
            alu_out_write = 1'b1;
            state_d       = StWb;
          end
          OpLoad, OpStore: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SrcBImm;
            alu_out_write = 1'b1;
            state_d       = StMem;
          end
          OpBranch: begin
            alu_src_a = 1'b1;
            alu_op    = AluBranch;
            if (bcond) begin
              state_d = StBrTaken;
            end else begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = StIf;
            end
          end
          // Live ALU computes the target while ALUOut still holds PC + 4 for rd.
          OpJal, OpJalr: begin
            alu_src_a = (opcode == OpJalr);
            alu_src_b = SrcBImm;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            state_d   = StIf;
          end
          OpEcall: begin
            if (halt_req) begin
              state_d = StHalt;
            end else begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = StIf;
            end
          end
          default: begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_d   = StIf;
          end
        endcase
      end

      StMem: begin
        i_or_d = 1'b1;
        if (opcode == OpStore) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = SrcBFour;
            pc_write  = 1'b1;
            state_d   = StIf;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = StWb;
          end
        end
      end

      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OpLoad);
        alu_src_b  = SrcBFour;
        pc_write   = 1'b1;
        state_d    = StIf;
      end

      StBrTaken: begin
        alu_src_b = SrcBImm;
        pc_write  = 1'b1;
        state_d   = StIf;
      end

      StHalt: begin
        is_halted = 1'b1;
      end

      default: begin
        state_d = StIf;
      end
    endcase

    // Reset gates every output combinationally so nothing fires while reset_n is low.
    if (!reset_n) begin
      state_d       = StIf;
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SrcBReg;
      alu_op        = AluAdd;
      alu_out_write = 1'b0;
      is_halted     = 1'b0;
    end
  end

  assign state = state_q;

endmodule
